lab2_cmd_parser: RTL
====================

# lab2_cmd_parser

Upstream command stage for the Lab 2 adder/subtractor. It consumes received ASCII bytes of the form `<hex digit><op><hex digit><terminator>`, decodes them into two 8-bit operands and a subtract flag, and issues a one-cycle start pulse to the adder. It then holds those outputs stable until the adder's ready pulse returns, or until a timeout expires. Malformed input is rejected with an error pulse, and the parser resynchronises to the start of a new command.

## Interface
Parameters:
- WAIT_MAX, 15: maximum cycles spent in S_WAIT for the adder ready pulse before timeout; 4-bit counter.

Ports:
- clk  in  1  global clock; all logic on posedge.
- Gl_rst_n  in  1  reset, asynchronous and active-low.
- rx_data  in  8  received ASCII byte; qualified by rx_valid.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle.
- L2_adder_rdy  in  1  adder result-ready pulse.
- Gl_r1  out  8  operand 1: decoded hex digit, zero-extended.
- Gl_r2  out  8  operand 2: decoded hex digit, zero-extended.
- Gl_subtract  out  1  1 when op was '-'.
- Gl_adder_start  out  1  one-cycle start pulse to the adder.
- busy  out  1  high while in S_WAIT.
- cmd_err  out  1  one-cycle pulse on rejected char or timeout.
- rx_drop  out  1  one-cycle pulse when a byte arrives in S_WAIT.
- echo_data  out  8  echoed byte; see Configuration.
- echo_valid  out  1  echo strobe; see Configuration.

## Operation
- Accepted characters:
  - digits 0x30–0x39, 0x41–0x46 and 0x61–0x66 decode to 0–15;
  - op '+' (0x2B) and '-' (0x2D);
  - terminator '=' (0x3D) or CR (0x0D);
  - space (0x20) is ignored in every state except S_WAIT.
- FSM states: S_D1 → S_OP → S_D2 → S_EQ → S_WAIT → S_D1.
  - S_D1: a digit is stored in shadow r1; go to S_OP.
  - S_OP: '+' or '-' is stored in shadow sub; go to S_D2.
  - S_D2: a digit is stored in shadow r2; go to S_EQ.
  - S_EQ: on a terminator, copy the shadows to Gl_r1, Gl_r2 and Gl_subtract, assert Gl_adder_start, clear the timeout counter, and go to S_WAIT.
  - S_WAIT: on L2_adder_rdy, go to S_D1. If the counter reaches WAIT_MAX, pulse cmd_err and go to S_D1.
- Any character not legal in the current state (S_D1–S_EQ) pulses cmd_err, discards the shadows, and returns to S_D1. The offending byte is not reinterpreted.
- In S_WAIT every rx_valid pulses rx_drop and the byte is discarded.
- Simultaneous events:
  - L2_adder_rdy and rx_valid in the same S_WAIT cycle: rdy takes priority (go to S_D1) and the byte is dropped, pulsing rx_drop.
  - L2_adder_rdy in the same cycle the counter hits WAIT_MAX: rdy wins and no cmd_err is raised.
  - L2_adder_rdy outside S_WAIT is ignored.
- Gl_r1, Gl_r2 and Gl_subtract change only on terminator acceptance and hold until the next accepted terminator.

## Timing
- Reset values (asynchronous): state S_D1, all shadows and the counter 0, every output 0.
- Gl_adder_start is registered: it asserts the cycle after the terminator's rx_valid, for exactly one cycle. Gl_r1, Gl_r2 and Gl_subtract update on the same edge.
- busy rises with Gl_adder_start. It falls the cycle after L2_adder_rdy or after the timeout.
- cmd_err and rx_drop are registered, one cycle after their cause.
- With the current adder, rdy arrives about 5 cycles after start, so the default WAIT_MAX has margin.
- Back-to-back rx_valid on consecutive cycles is supported; the throughput is one byte per cycle.
- Reset asserted mid-command aborts the command: no start pulse is issued, and a pending start is cleared.

## Configuration
- CMD_ECHO_EN defined: every byte accepted in S_D1–S_EQ (including spaces) is driven on echo_data with echo_valid one cycle later. Rejected and dropped bytes are not echoed.
- CMD_ECHO_EN undefined: echo_data and echo_valid are tied to 0 and no echo registers are built. The ports remain present.

## Structure
- Shared package lab2_pkg holds:
  - the state enum type;
  - ASCII constants for the characters above;
  - WAIT_MAX default.
- Sub-module ascii_hex_decode: combinational, 8-bit byte in, `{is_hex, nibble[3:0]}` out. It is instantiated once and shared by S_D1 and S_D2.

## Test plan
- Bytes "3+4=" → one Gl_adder_start; Gl_r1=0x03, Gl_r2=0x04, Gl_subtract=0; busy until rdy, then S_D1.
- Bytes "a - F\r" → Gl_r1=0x0A, Gl_r2=0x0F, Gl_subtract=1; spaces ignored; exactly one start.
- Bytes "3*4=" → cmd_err on '*'; no start pulse; following "1+1=" → Gl_r1=Gl_r2=0x01 with start.
- Command accepted and L2_adder_rdy held low → cmd_err exactly WAIT_MAX+1 cycles after start; busy drops; the next command is accepted.
- Bytes sent in S_WAIT, including one coinciding with rdy → rx_drop per byte, outputs unchanged, state returns to S_D1.
- Gl_rst_n pulsed low after "5+" → all outputs 0; subsequent "2-1=" gives Gl_r1=0x02, Gl_r2=0x01, Gl_subtract=1; with CMD_ECHO_EN, echo_data matches each accepted byte one cycle later.

Source files
------------

// File: rtl/lab2_pkg.sv
// Shared definitions for the Lab 2 command parser: FSM state type, ASCII
// constants for the command grammar, and the default adder-ready timeout.
package lab2_pkg;

   // state  | meaning
   // S_D1   | waiting for first hex digit
   // S_OP   | waiting for '+' or '-'
   // S_D2   | waiting for second hex digit
   // S_EQ   | waiting for terminator ('=' or CR)
   // S_WAIT | start issued, waiting for adder ready or timeout
   typedef enum logic [2:0] {
      S_D1   = 3'd0,
      S_OP   = 3'd1,
      S_D2   = 3'd2,
      S_EQ   = 3'd3,
      S_WAIT = 3'd4
   } state_t;

   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_EQ    = 8'h3D;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam logic [3:0] WAIT_MAX_DEF = 4'd15;

   // True when byte c is acceptable in parsing state st. Spaces are legal
   // (and ignored) in every parsing state; S_WAIT never accepts anything.
   function automatic logic char_legal(state_t st, logic [7:0] c, logic is_hex);
      logic ok;
      ok = 1'b0;
      if (st != S_WAIT && c == ASCII_SPACE) begin
         ok = 1'b1;
      end else if (st == S_D1 || st == S_D2) begin
         ok = is_hex;
      end else if (st == S_OP) begin
         ok = (c == ASCII_PLUS) || (c == ASCII_MINUS);
      end else if (st == S_EQ) begin
         ok = (c == ASCII_EQ) || (c == ASCII_CR);
      end
      return ok;
   endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex digit decoder.
// Ports:
//   byte_i  in  8  ASCII byte
//   dec_o   out 5  {is_hex, nibble[3:0]}; nibble is 0 when is_hex is 0
module ascii_hex_decode (
   input  logic [7:0] byte_i,
   output logic [4:0] dec_o
);

   logic is_digit;
   logic is_alpha;

   always_comb begin
      is_digit = (byte_i >= 8'h30) && (byte_i <= 8'h39);
      is_alpha = ((byte_i >= 8'h41) && (byte_i <= 8'h46)) ||
                 ((byte_i >= 8'h61) && (byte_i <= 8'h66));
      dec_o = 5'd0;
      // 'A'/'a' have low nibble 1, so adding 9 maps A..F onto 10..15.
      if (is_digit) begin
         dec_o = {1'b1, byte_i[3:0]};
      end else if (is_alpha) begin
         dec_o = {1'b1, byte_i[3:0] + 4'd9};
      end
   end

endmodule

// File: rtl/lab2_cmd_parser.sv
// Command parser for the Lab 2 adder/subtractor. Parses "<hex><op><hex><term>",
// issues a one-cycle start pulse with operands, then waits for the adder
// ready pulse or a timeout.
// Optional feature macro: CMD_ECHO_EN (echo accepted bytes one cycle later).
// Ports:
//   clk, Gl_rst_n        clock, async active-low reset
//   rx_data/rx_valid     received byte and its strobe
//   L2_adder_rdy         adder result-ready pulse
//   Gl_r1, Gl_r2         zero-extended operands
//   Gl_subtract          1 for '-'
//   Gl_adder_start       one-cycle start pulse
//   busy                 high while waiting for the adder
//   cmd_err              pulse on rejected byte or timeout
//   rx_drop              pulse on byte received while busy
//   echo_data/echo_valid echo of accepted bytes (0 without CMD_ECHO_EN)
module lab2_cmd_parser
   import lab2_pkg::*;
#(
   parameter logic [3:0] WAIT_MAX = WAIT_MAX_DEF
) (
   input  logic       clk,
   input  logic       Gl_rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       L2_adder_rdy,
   output logic [7:0] Gl_r1,
   output logic [7:0] Gl_r2,
   output logic       Gl_subtract,
   output logic       Gl_adder_start,
   output logic       busy,
   output logic       cmd_err,
   output logic       rx_drop,
   output logic [7:0] echo_data,
   output logic       echo_valid
);

   state_t     state_q, state_d;
   logic [3:0] r1_sh_q, r1_sh_d;
   logic [3:0] r2_sh_q, r2_sh_d;
   logic       sub_sh_q, sub_sh_d;
   logic [7:0] r1_q, r1_d;
   logic [7:0] r2_q, r2_d;
   logic       sub_q, sub_d;
   logic       start_q, start_d;
   logic       err_q, err_d;
   logic       drop_q, drop_d;
   logic [3:0] cnt_q, cnt_d;

   logic [4:0] dec;
   logic       legal;

   ascii_hex_decode u_hex (
      .byte_i (rx_data),
      .dec_o  (dec)
   );

   assign legal = char_legal(state_q, rx_data, dec[4]);

   always_comb begin
      state_d  = state_q;
      r1_sh_d  = r1_sh_q;
      r2_sh_d  = r2_sh_q;
      sub_sh_d = sub_sh_q;
      r1_d     = r1_q;
      r2_d     = r2_q;
      sub_d    = sub_q;
      cnt_d    = cnt_q;
      start_d  = 1'b0;
      err_d    = 1'b0;
      drop_d   = 1'b0;

      if (state_q == S_WAIT) begin
         drop_d = rx_valid;
         // Ready beats the timeout when both land in the same cycle.
         if (L2_adder_rdy) begin
            state_d = S_D1;
         end else if (cnt_q == WAIT_MAX) begin
            err_d   = 1'b1;
            state_d = S_D1;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end else if (rx_valid) begin
         if (!legal) begin
            err_d    = 1'b1;
            r1_sh_d  = 4'd0;
            r2_sh_d  = 4'd0;
            sub_sh_d = 1'b0;
            state_d  = S_D1;
         end else if (rx_data != ASCII_SPACE) begin
            case (state_q)
               S_D1: begin
                  r1_sh_d = dec[3:0];
                  state_d = S_OP;
               end
               S_OP: begin
                  sub_sh_d = (rx_data == ASCII_MINUS);
                  state_d  = S_D2;
               end
               S_D2: begin
                  r2_sh_d = dec[3:0];
                  state_d = S_EQ;
               end
               S_EQ: begin
                  r1_d    = {4'd0, r1_sh_q};
                  r2_d    = {4'd0, r2_sh_q};
                  sub_d   = sub_sh_q;
                  start_d = 1'b1;
                  cnt_d   = 4'd0;
                  state_d = S_WAIT;
               end
               default: state_d = S_D1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge Gl_rst_n) begin
      if (!Gl_rst_n) begin
         state_q  <= S_D1;
         r1_sh_q  <= 4'd0;
         r2_sh_q  <= 4'd0;
         sub_sh_q <= 1'b0;
         r1_q     <= 8'd0;
         r2_q     <= 8'd0;
         sub_q    <= 1'b0;
         start_q  <= 1'b0;
         err_q    <= 1'b0;
         drop_q   <= 1'b0;
         cnt_q    <= 4'd0;
      end else begin
         state_q  <= state_d;
         r1_sh_q  <= r1_sh_d;
         r2_sh_q  <= r2_sh_d;
         sub_sh_q <= sub_sh_d;
         r1_q     <= r1_d;
         r2_q     <= r2_d;
         sub_q    <= sub_d;
         start_q  <= start_d;
         err_q    <= err_d;
         drop_q   <= drop_d;
         cnt_q    <= cnt_d;
      end
   end

   assign Gl_r1          = r1_q;
   assign Gl_r2          = r2_q;
   assign Gl_subtract    = sub_q;
   assign Gl_adder_start = start_q;
   assign busy           = (state_q == S_WAIT);
   assign cmd_err        = err_q;
   assign rx_drop        = drop_q;

`ifdef CMD_ECHO_EN
   logic [7:0] echo_data_q, echo_data_d;
   logic       echo_valid_q, echo_valid_d;

   always_comb begin
      echo_valid_d = rx_valid && legal;
      echo_data_d  = echo_valid_d ? rx_data : echo_data_q;
   end

   always_ff @(posedge clk or negedge Gl_rst_n) begin
      if (!Gl_rst_n) begin
         echo_data_q  <= 8'd0;
         echo_valid_q <= 1'b0;
      end else begin
         echo_data_q  <= echo_data_d;
         echo_valid_q <= echo_valid_d;
      end
   end

   assign echo_data  = echo_data_q;
   assign echo_valid = echo_valid_q;
`else
   assign echo_data  = 8'd0;
   assign echo_valid = 1'b0;
`endif

endmodule
